ex_ctrl_stage: RTL and testbench

- Parametrised execute-stage control unit for the RV pipeline.
- Registers the decoded EX control word (mux selects, ALU control) from the ID/EX boundary.
- Adds a multi-cycle operation sequencer (e.g. divide) that stalls upstream for a configurable latency.
- Supports pipeline flush and a valid/ready handshake toward decode.

---
 rtl/ex_ctrl_if.sv | 38 +++
 rtl/ex_ctrl_stage.sv | 124 ++++++++++++
 tb/tb_ex_ctrl_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_ctrl_if.sv
// Decode <-> EX control-stage bus: op handshake, decoded control fields and
// registered EX select outputs. Decode side uses master, EX stage uses slave.
interface ex_ctrl_if #(
  parameter int OP_W      = 3,
  parameter int ALU_CNT_W = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      ex;
  logic [1:0]           jump_t;
  logic                 slt;
  logic                 lui;
  logic                 mc;
  logic                 flush;
  logic                 sign_bit;
  logic                 out_valid;
  logic                 m2_1_cnt;
  logic                 m2_2_cnt;
  logic                 m2_3_cnt;
  logic                 m2_4_cnt;
  logic [1:0]           m4_2_cnt;
  logic [ALU_CNT_W-1:0] alu_cnt;
  logic                 stall;
  logic                 mc_done;
  logic [31:0]          stall_cycles;

  modport master (
    output in_valid, ex, jump_t, slt, lui, mc, flush, sign_bit,
    input  in_ready, out_valid, m2_1_cnt, m2_2_cnt, m2_3_cnt, m2_4_cnt,
           m4_2_cnt, alu_cnt, stall, mc_done, stall_cycles
  );

  modport slave (
    input  in_valid, ex, jump_t, slt, lui, mc, flush, sign_bit,
    output in_ready, out_valid, m2_1_cnt, m2_2_cnt, m2_3_cnt, m2_4_cnt,
           m4_2_cnt, alu_cnt, stall, mc_done, stall_cycles
  );
endinterface

// File: rtl/ex_ctrl_stage.sv
// Execute-stage control: registers the decoded EX control word and sequences
// multi-cycle ops with an upstream stall. Optional macro EX_STALL_PERF_CNT_EN.
module ex_ctrl_stage #(
  parameter int OP_W      = 3,
  parameter int ALU_CNT_W = 3,
  parameter int MC_LAT    = 4,
  parameter int CNT_W     = 8
) (
  input  logic    clk,
  input  logic    rst,
  ex_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 w_in_ready;
  logic                 w_accept;

  logic                 r_out_valid;
  logic                 r_m2_1;
  logic                 r_m2_2;
  logic                 r_m2_3;
  logic [1:0]           r_m4_2;
  logic [ALU_CNT_W-1:0] r_alu_cnt;

  // Zero-extend or truncate the opcode to the ALU control width.
  function automatic logic [ALU_CNT_W-1:0] fit_alu(input logic [OP_W-1:0] op);
    logic [OP_W+ALU_CNT_W-1:0] wide;
    wide = {{ALU_CNT_W{1'b0}}, op};
    return wide[ALU_CNT_W-1:0];
  endfunction

  function automatic logic [1:0] sel_m4_2(input logic is_slt, input logic is_lui);
    if (is_slt)      return 2'b10;
    else if (is_lui) return 2'b01;
    else             return 2'b00;
  endfunction

  assign w_in_ready = (r_state == S_IDLE);
  assign w_accept   = bus.in_valid & w_in_ready & ~bus.flush;

  // Stage p0 -> p1: sequencer state and latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && bus.mc) begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = CNT_W'(MC_LAT - 1);
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) w_state_nxt = S_DONE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: control word; held unchanged while a multi-cycle op runs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_m2_1      <= 1'b0;
      r_m2_2      <= 1'b0;
      r_m2_3      <= 1'b0;
      r_m4_2      <= 2'b00;
      r_alu_cnt   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_m2_1      <= (bus.jump_t == 2'b11);
      r_m2_2      <= (bus.jump_t != 2'b01);
      r_m2_3      <= bus.ex[OP_W-1] | (bus.jump_t == 2'b01);
      r_m4_2      <= sel_m4_2(bus.slt, bus.lui);
      r_alu_cnt   <= fit_alu(bus.ex);
    end else if (bus.flush || r_state != S_BUSY) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef EX_STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_stall_cycles <= '0;
    else if (r_state == S_BUSY) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'd0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.m2_1_cnt  = r_m2_1;
  assign bus.m2_2_cnt  = r_m2_2;
  assign bus.m2_3_cnt  = r_m2_3;
  assign bus.m2_4_cnt  = bus.sign_bit & r_out_valid;
  assign bus.m4_2_cnt  = r_m4_2;
  assign bus.alu_cnt   = r_alu_cnt;
  assign bus.stall     = (r_state == S_BUSY);
  assign bus.mc_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_ex_ctrl_stage.sv
// Randomised and directed bench for ex_ctrl_stage against an op-level reference model.
module tb_ex_ctrl_stage;
  localparam int OP_W      = 3;
  localparam int ALU_CNT_W = 3;
  localparam int MC_LAT    = 4;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_ctrl_if #(.OP_W(OP_W), .ALU_CNT_W(ALU_CNT_W)) bus ();

  ex_ctrl_stage #(
    .OP_W(OP_W), .ALU_CNT_W(ALU_CNT_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stall cycles still owed, completion pending, held op.
  int          m_busy;
  bit          m_done;
  bit          m_valid;
  int          m_ex;
  int          m_jt;
  bit          m_slt;
  bit          m_lui;
  int unsigned m_perf;
  int          m_acc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_valid = 0;
    m_ex = 0; m_jt = 0; m_slt = 0; m_lui = 0;
    m_perf = 0;
  endtask

  task automatic check_all();
    chk("in_ready",  32'(bus.in_ready),  32'(m_busy == 0 && !m_done));
    chk("stall",     32'(bus.stall),     32'(m_busy > 0));
    chk("mc_done",   32'(bus.mc_done),   32'(m_done));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("m2_4",      32'(bus.m2_4_cnt),  32'(bus.sign_bit && m_valid));
`ifdef EX_STALL_PERF_CNT_EN
    chk("stall_cycles", bus.stall_cycles, m_perf);
`else
    chk("stall_cycles", bus.stall_cycles, 32'd0);
`endif
    if (m_valid) begin
      chk("m2_1", 32'(bus.m2_1_cnt), 32'(m_jt == 3));
      chk("m2_2", 32'(bus.m2_2_cnt), 32'(m_jt != 1));
      chk("m2_3", 32'(bus.m2_3_cnt), 32'(m_ex >= (1 << (OP_W - 1)) || m_jt == 1));
      chk("m4_2", 32'(bus.m4_2_cnt), 32'(m_slt ? 2 : (m_lui ? 1 : 0)));
      chk("alu_cnt", 32'(bus.alu_cnt), 32'(m_ex % (1 << ALU_CNT_W)));
    end
  endtask

  task automatic model_edge();
    bit ready_now;
    ready_now = (m_busy == 0 && !m_done);
    if (m_busy > 0) m_perf++;
    if (bus.flush) begin
      m_busy = 0; m_done = 0; m_valid = 0;
    end else if (ready_now && bus.in_valid) begin
      m_acc++;
      m_valid = 1;
      m_ex = int'(bus.ex); m_jt = int'(bus.jump_t);
      m_slt = bus.slt; m_lui = bus.lui;
      if (bus.mc) m_busy = MC_LAT;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_done = 1;
    end else begin
      m_done = 0; m_valid = 0;
    end
  endtask

  // Called just after a rising edge; checks mid-cycle and returns after the next edge.
  task automatic step(input bit iv, input int ex, input int jt, input bit slt,
                      input bit lui, input bit mc, input bit fl, input bit sb);
    bus.in_valid = iv; bus.ex = OP_W'(ex); bus.jump_t = 2'(jt);
    bus.slt = slt; bus.lui = lui; bus.mc = mc; bus.flush = fl; bus.sign_bit = sb;
    #4;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int base;
    int acc0;
    int p_ex, p_jt;
    bit p_slt, p_lui, p_mc;

    bus.in_valid = 0; bus.ex = '0; bus.jump_t = '0; bus.slt = 0; bus.lui = 0;
    bus.mc = 0; bus.flush = 0; bus.sign_bit = 0;
    model_reset();
    m_acc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
    idle();

    // Single-cycle op
    step(1, 3'b101, 2'b01, 1, 0, 0, 0, 0);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_m2_3",  32'(bus.m2_3_cnt),  32'd1);
    chk("single_m2_2",  32'(bus.m2_2_cnt),  32'd0);
    chk("single_m2_1",  32'(bus.m2_1_cnt),  32'd0);
    chk("single_m4_2",  32'(bus.m4_2_cnt),  32'd2);
    chk("single_alu",   32'(bus.alu_cnt),   32'd5);
    chk("single_stall", 32'(bus.stall),     32'd0);
    idle();

    // Multi-cycle op: stall cycles 1..4, mc_done cycle 5, ready cycle 6
    base = int'(bus.stall_cycles);
    step(1, 3'b011, 2'b00, 0, 1, 1, 0, 0);
    for (int k = 1; k <= MC_LAT; k++) begin
      chk("mc_stall", 32'(bus.stall), 32'd1);
      idle();
    end
    chk("mc_done_pulse", 32'(bus.mc_done), 32'd1);
    chk("mc_done_nostall", 32'(bus.stall), 32'd0);
    idle();
    chk("mc_ready_again", 32'(bus.in_ready), 32'd1);
    chk("mc_done_once", 32'(bus.mc_done), 32'd0);
`ifdef EX_STALL_PERF_CNT_EN
    chk("perf_delta", bus.stall_cycles - 32'(base), 32'd4);
`else
    chk("perf_tied", bus.stall_cycles, 32'(base));
`endif

    // Flush during BUSY
    step(1, 3'b110, 2'b10, 0, 0, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    step(1, 3'b001, 2'b00, 0, 1, 0, 0, 0);
    chk("after_flush_accept", 32'(bus.out_valid), 32'd1);
    chk("after_flush_alu", 32'(bus.alu_cnt), 32'd1);

    // Flush together with in_valid: flush wins
    step(1, 3'b010, 2'b11, 0, 0, 0, 1, 1);
    chk("flush_in_valid", 32'(bus.out_valid), 32'd0);
    bus.sign_bit = 1'b1; #1;
    chk("flush_m2_4", 32'(bus.m2_4_cnt), 32'd0);
    #(-0);
    @(posedge clk); #1;
    idle();

    // Back-pressure: new op held through BUSY/DONE, accepted once
    acc0 = m_acc;
    step(1, 3'b100, 2'b00, 0, 0, 1, 0, 0);
    for (int k = 0; k < MC_LAT + 2; k++) step(1, 3'b111, 2'b11, 0, 1, 0, 0, 1);
    chk("bp_accept_count", 32'(m_acc - acc0), 32'd2);
    chk("bp_alu", 32'(bus.alu_cnt), 32'd7);
    chk("bp_m2_1", 32'(bus.m2_1_cnt), 32'd1);
    idle();
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of BUSY
    step(1, 3'b101, 2'b00, 0, 0, 1, 0, 1);
    idle();
    bus.sign_bit = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall",     32'(bus.stall),     32'd0);
    chk("rst_mc_done",   32'(bus.mc_done),   32'd0);
    chk("rst_m2_4",      32'(bus.m2_4_cnt),  32'd0);
    chk("rst_fields",    32'({bus.m2_1_cnt, bus.m2_2_cnt, bus.m2_3_cnt, bus.m4_2_cnt, bus.alu_cnt}), 32'd0);
    chk("rst_perf",      bus.stall_cycles, 32'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    chk("rst_release_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < MC_LAT + 2; k++) idle();

    // Randomised traffic: decode holds each op until it is taken
    p_ex = $urandom_range(0, 7); p_jt = $urandom_range(0, 3);
    p_slt = 1'($urandom); p_lui = 1'($urandom); p_mc = ($urandom_range(0, 9) < 3);
    for (int c = 0; c < 3000; c++) begin
      bit iv, fl, taken;
      iv = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 99) < 6);
      taken = iv && !fl && (m_busy == 0 && !m_done);
      step(iv, p_ex, p_jt, p_slt, p_lui, p_mc, fl, 1'($urandom));
      if (taken) begin
        p_ex = $urandom_range(0, 7); p_jt = $urandom_range(0, 3);
        p_slt = 1'($urandom); p_lui = 1'($urandom); p_mc = ($urandom_range(0, 9) < 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
